// File: rtl/flash_audio_pkg.sv
// Shared types and constants for the flash sample unpacker.
package flash_audio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    EMIT
  } state_e;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned DEF_ADDR_W     = 23;
  localparam logic [22:0] DEF_START_ADDR = 23'h000000;
  localparam logic [22:0] DEF_END_ADDR   = 23'h07FFFF;

endpackage

// File: rtl/flash_addr_wrap_counter.sv
// Flash word-address counter: starts at START_ADDR, steps on advance,
// wraps from END_ADDR (inclusive) back to START_ADDR.
module flash_addr_wrap_counter #(
  parameter int unsigned        ADDR_W     = 23,
  parameter logic [ADDR_W-1:0]  START_ADDR = '0,
  parameter logic [ADDR_W-1:0]  END_ADDR   = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (advance) begin
      addr_d = (addr_q == END_ADDR) ? START_ADDR : addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= START_ADDR;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/flash_sample_unpacker.sv
// Fetches packed 8-bit samples from flash over Avalon-MM and emits one
// sample per sample_tick, looping over a fixed word-address window.
module flash_sample_unpacker
  import flash_audio_pkg::*;
#(
  parameter int unsigned       ADDR_W     = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(DEF_START_ADDR),
  parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(DEF_END_ADDR)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              sample_tick,
  output logic              flash_mem_read,
  output logic [ADDR_W-1:0] flash_mem_address,
  output logic [3:0]        flash_mem_byteenable,
  input  logic              flash_mem_waitrequest,
  input  logic [31:0]       flash_mem_readdata,
  input  logic              flash_mem_readdatavalid,
  output logic [7:0]        audio_data,
  output logic              start,
  output logic              underrun
);

  state_e      state_q, state_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] word_buf_q, word_buf_d;
  logic [7:0]  audio_q, audio_d;
  logic        start_q, start_d;
  logic        pending_q, pending_d;
  logic        underrun_q, underrun_d;
  logic        serve;
  logic        advance;
  logic        last_byte;

  flash_addr_wrap_counter #(
    .ADDR_W     (ADDR_W),
    .START_ADDR (START_ADDR),
    .END_ADDR   (END_ADDR)
  ) u_addr (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (advance),
    .addr    (flash_mem_address)
  );

  assign last_byte = (byte_idx_q == 2'(BYTES_PER_WORD - 1));

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    word_buf_d = word_buf_q;
    audio_d    = audio_q;
    start_d    = 1'b0;
    serve      = 1'b0;
    advance    = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) state_d = REQ;
      end
      REQ: begin
        if (!flash_mem_waitrequest) state_d = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (flash_mem_readdatavalid) begin
          word_buf_d = flash_mem_readdata;
          byte_idx_d = '0;
          state_d    = enable ? EMIT : IDLE;
        end
      end
      EMIT: begin
        // A tick landing on the cycle after a start is deferred via pending,
        // so start never asserts on back-to-back cycles.
        if (sample_tick || pending_q) begin
          if (!start_q) begin
            serve      = 1'b1;
            audio_d    = word_buf_q[{byte_idx_q, 3'b000} +: 8];
            start_d    = 1'b1;
            byte_idx_d = byte_idx_q + 2'd1;
            if (last_byte) begin
              advance = 1'b1;
              state_d = enable ? REQ : IDLE;
            end
          end
        end else if (!enable) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    pending_d = pending_q;
    if (serve) begin
      pending_d = sample_tick && pending_q;
    end else if (sample_tick) begin
      pending_d = 1'b1;
    end
    underrun_d = underrun_q | (sample_tick & pending_q & ~serve);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      byte_idx_q <= '0;
      word_buf_q <= '0;
      audio_q    <= '0;
      start_q    <= 1'b0;
      pending_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      word_buf_q <= word_buf_d;
      audio_q    <= audio_d;
      start_q    <= start_d;
      pending_q  <= pending_d;
      underrun_q <= underrun_d;
    end
  end

  assign flash_mem_read       = (state_q == REQ);
  assign flash_mem_byteenable = 4'hF;
  assign audio_data           = audio_q;
  assign start                = start_q;
  assign underrun             = underrun_q;

endmodule

// File: tb/tb_flash_sample_unpacker.sv
// Scoreboard bench for flash_sample_unpacker with a configurable Avalon slave.
module tb_flash_sample_unpacker;

  localparam int unsigned AW = 23;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          sample_tick;
  logic          flash_mem_read;
  logic [AW-1:0] flash_mem_address;
  logic [3:0]    flash_mem_byteenable;
  logic          flash_mem_waitrequest;
  logic [31:0]   flash_mem_readdata;
  logic          flash_mem_readdatavalid;
  logic [7:0]    audio_data;
  logic          start;
  logic          underrun;

  int tests_run = 0;
  int fails     = 0;
  int rdv_count = 0;
  int start_cnt = 0;
  int ws_cfg    = 0;
  int lat_cfg   = 0;

  logic [7:0]    exp_q[$];
  logic [AW-1:0] addr_log[$];
  logic          mon_prev_start = 1'b0;

  flash_sample_unpacker #(
    .ADDR_W     (AW),
    .START_ADDR (23'h000000),
    .END_ADDR   (23'h000003)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .enable                  (enable),
    .sample_tick             (sample_tick),
    .flash_mem_read          (flash_mem_read),
    .flash_mem_address       (flash_mem_address),
    .flash_mem_byteenable    (flash_mem_byteenable),
    .flash_mem_waitrequest   (flash_mem_waitrequest),
    .flash_mem_readdata      (flash_mem_readdata),
    .flash_mem_readdatavalid (flash_mem_readdatavalid),
    .audio_data              (audio_data),
    .start                   (start),
    .underrun                (underrun)
  );

  always #10 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    if (a == '0) return 32'h807F01FF;
    return 32'hA3B2C1D0 + 32'(a);
  endfunction

  // Avalon slave: waitrequest held ws_cfg cycles, data lat_cfg cycles after accept.
  initial begin : slave
    int       wr_cnt;
    int       lat_cnt;
    bit       busy;
    logic [AW-1:0] pend_addr;
    wr_cnt = 0; lat_cnt = 0; busy = 0; pend_addr = '0;
    flash_mem_waitrequest   = 1'b1;
    flash_mem_readdatavalid = 1'b0;
    flash_mem_readdata      = '0;
    forever begin
      @(negedge clk);
      flash_mem_readdatavalid = 1'b0;
      flash_mem_waitrequest   = 1'b1;
      if (rst_n !== 1'b1) begin
        busy   = 0;
        wr_cnt = 0;
      end else begin
        if (busy) begin
          if (lat_cnt == 0) begin
            flash_mem_readdatavalid = 1'b1;
            flash_mem_readdata      = mem_word(pend_addr);
            busy = 0;
            rdv_count++;
          end else begin
            lat_cnt--;
          end
        end
        if (flash_mem_read === 1'b1 && !busy) begin
          if (wr_cnt < ws_cfg) begin
            wr_cnt++;
          end else begin
            flash_mem_waitrequest = 1'b0;
            busy      = 1;
            lat_cnt   = lat_cfg;
            pend_addr = flash_mem_address;
            addr_log.push_back(pend_addr);
            wr_cnt    = 0;
          end
        end
      end
    end
  end

  // Output monitor: every start pops one expected sample.
  initial begin : monitor
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && start === 1'b1) begin
        start_cnt++;
        tests_run++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL sample_unexpected: start with audio_data=%02h, required no start", audio_data);
        end else begin
          e = exp_q.pop_front();
          if (audio_data !== e) begin
            fails++;
            $display("FAIL sample_value: audio_data=%02h required %02h", audio_data, e);
          end
        end
        tests_run++;
        if (mon_prev_start) begin
          fails++;
          $display("FAIL start_consecutive: start high two cycles running, required single-cycle");
        end
      end
      mon_prev_start = (rst_n === 1'b1) && (start === 1'b1);
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, fails + 1);
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    enable = 1'b0; sample_tick = 1'b0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    addr_log.delete();
    exp_q.delete();
    rdv_count = 0;
  endtask

  task automatic wait_reads(input int n, input string what);
    int budget = 300;
    while (addr_log.size() < n && budget > 0) begin
      @(negedge clk); #1; budget--;
    end
    if (addr_log.size() < n) begin
      tests_run++; fails++;
      $display("FAIL %s_read_timeout: reads=%0d required %0d", what, addr_log.size(), n);
    end
  endtask

  task automatic wait_rdv(input int n, input string what);
    int budget = 300;
    while (rdv_count < n && budget > 0) begin
      @(negedge clk); #1; budget--;
    end
    if (rdv_count < n) begin
      tests_run++; fails++;
      $display("FAIL %s_data_timeout: words=%0d required %0d", what, rdv_count, n);
    end
  endtask

  task automatic push_word(input logic [AW-1:0] a);
    logic [31:0] w;
    w = mem_word(a);
    for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; sample_tick = 1'b0;
    ws_cfg = 0; lat_cfg = 0;
    repeat (3) @(negedge clk);
    tests_run++; if (flash_mem_read !== 1'b0) begin fails++; $display("FAIL reset_read: got %b required 0", flash_mem_read); end
    tests_run++; if (flash_mem_address !== 23'h0) begin fails++; $display("FAIL reset_addr: got %h required 000000", flash_mem_address); end
    tests_run++; if (audio_data !== 8'h00) begin fails++; $display("FAIL reset_audio: got %h required 00", audio_data); end
    tests_run++; if (start !== 1'b0) begin fails++; $display("FAIL reset_start: got %b required 0", start); end
    tests_run++; if (underrun !== 1'b0) begin fails++; $display("FAIL reset_underrun: got %b required 0", underrun); end
    tests_run++; if (flash_mem_byteenable !== 4'hF) begin fails++; $display("FAIL byteenable: got %h required f", flash_mem_byteenable); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    tests_run++; if (flash_mem_read !== 1'b0) begin fails++; $display("FAIL idle_no_read: got %b required 0", flash_mem_read); end
  endtask

  task automatic test_basic();
    logic [7:0] bytes_exp [4];
    bytes_exp = '{8'hFF, 8'h01, 8'h7F, 8'h80};
    ws_cfg = 3; lat_cfg = 1;
    enable = 1'b1;
    wait_rdv(1, "basic");
    tests_run++; if (addr_log.size() != 1 || addr_log[0] !== 23'h0) begin
      fails++; $display("FAIL basic_first_read: reads=%0d required one read at 000000", addr_log.size());
    end
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(bytes_exp[k]);
      tick();
      tests_run++; if (start !== 1'b1) begin fails++; $display("FAIL basic_latency%0d: start=%b required 1", k, start); end
      repeat (3) @(negedge clk);
      tests_run++; if (audio_data !== bytes_exp[k]) begin fails++; $display("FAIL basic_hold%0d: audio_data=%02h required %02h", k, audio_data, bytes_exp[k]); end
    end
    tests_run++; if (flash_mem_address !== 23'h1) begin fails++; $display("FAIL basic_next_addr: got %h required 000001", flash_mem_address); end
    enable = 1'b0;
    repeat (10) @(negedge clk);
    tests_run++; if (exp_q.size() != 0) begin fails++; $display("FAIL basic_drain: %0d samples left, required 0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    int s0;
    logic [31:0] w;
    do_reset();
    ws_cfg = 0; lat_cfg = 0;
    s0 = start_cnt;
    enable = 1'b1;
    wait_rdv(1, "wrap");
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      w = mem_word(AW'(k / 4));
      exp_q.push_back(w[8*(k%4) +: 8]);
      tick();
      tests_run++; if (start !== 1'b1) begin fails++; $display("FAIL wrap_start%0d: start=%b required 1", k, start); end
      repeat (18) @(negedge clk);
    end
    wait_reads(5, "wrap");
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (i >= addr_log.size() || addr_log[i] !== AW'(i % 4)) begin
        fails++; $display("FAIL wrap_addr%0d: got %h required %h", i, (i < addr_log.size()) ? addr_log[i] : '1, AW'(i % 4));
      end
    end
    tests_run++; if (start_cnt - s0 != 16) begin fails++; $display("FAIL wrap_starts: got %0d required 16", start_cnt - s0); end
    tests_run++; if (underrun !== 1'b0) begin fails++; $display("FAIL wrap_underrun: got %b required 0", underrun); end
    enable = 1'b0;
    wait_rdv(5, "wrap_tail");
    repeat (4) @(negedge clk);
    tests_run++; if (exp_q.size() != 0) begin fails++; $display("FAIL wrap_drain: %0d samples left, required 0", exp_q.size()); end
  endtask

  task automatic test_pending_underrun();
    int s0;
    do_reset();
    ws_cfg = 0; lat_cfg = 40;
    enable = 1'b1;
    wait_reads(1, "pend");
    exp_q.push_back(8'hFF);
    s0 = start_cnt;
    repeat (2) @(negedge clk);
    tick();
    tests_run++; if (underrun !== 1'b0) begin fails++; $display("FAIL pend_first_tick_underrun: got %b required 0", underrun); end
    repeat (18) @(negedge clk);
    tick();
    tests_run++; if (underrun !== 1'b1) begin fails++; $display("FAIL pend_second_tick_underrun: got %b required 1", underrun); end
    tests_run++; if (start_cnt != s0) begin fails++; $display("FAIL pend_early_start: starts=%0d required 0", start_cnt - s0); end
    wait_rdv(1, "pend");
    @(negedge clk);
    @(negedge clk);
    tests_run++; if (start !== 1'b1) begin fails++; $display("FAIL pend_served_on_emit: start=%b required 1", start); end
    repeat (3) @(negedge clk);
    tests_run++; if (start_cnt - s0 != 1) begin fails++; $display("FAIL pend_served_once: starts=%0d required 1", start_cnt - s0); end
    exp_q.push_back(8'h01);
    tick();
    tests_run++; if (start !== 1'b1) begin fails++; $display("FAIL pend_next_tick: start=%b required 1", start); end
    repeat (5) @(negedge clk);
    tests_run++; if (underrun !== 1'b1) begin fails++; $display("FAIL pend_sticky: underrun=%b required 1", underrun); end
    enable = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++; if (exp_q.size() != 0) begin fails++; $display("FAIL pend_drain: %0d samples left, required 0", exp_q.size()); end
  endtask

  task automatic test_disable_in_wait();
    int s0;
    do_reset();
    ws_cfg = 0; lat_cfg = 10;
    enable = 1'b1;
    wait_reads(1, "dis");
    @(negedge clk);
    enable = 1'b0;
    s0 = start_cnt;
    wait_rdv(1, "dis");
    repeat (20) @(negedge clk);
    tests_run++; if (start_cnt != s0) begin fails++; $display("FAIL dis_no_start: starts=%0d required 0", start_cnt - s0); end
    tests_run++; if (addr_log.size() != 1) begin fails++; $display("FAIL dis_no_new_read: reads=%0d required 1", addr_log.size()); end
    tests_run++; if (flash_mem_read !== 1'b0) begin fails++; $display("FAIL dis_read_low: got %b required 0", flash_mem_read); end
    enable = 1'b1;
    wait_reads(2, "dis_resume");
    tests_run++; if (addr_log.size() < 2 || addr_log[1] !== 23'h0) begin fails++; $display("FAIL dis_refetch_addr: reads=%0d required second read at 000000", addr_log.size()); end
    wait_rdv(2, "dis_resume");
    @(negedge clk);
    exp_q.push_back(8'hFF);
    tick();
    tests_run++; if (start !== 1'b1) begin fails++; $display("FAIL dis_resume_start: start=%b required 1", start); end
    enable = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++; if (exp_q.size() != 0) begin fails++; $display("FAIL dis_drain: %0d samples left, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int budget;
    do_reset();
    ws_cfg = 0; lat_cfg = 0;
    enable = 1'b1;
    wait_rdv(1, "rstmid");
    @(negedge clk);
    push_word(23'h0);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) ws_cfg = 1000;
      tick();
      repeat (3) @(negedge clk);
    end
    budget = 20;
    while (flash_mem_read !== 1'b1 && budget > 0) begin @(negedge clk); budget--; end
    tests_run++; if (flash_mem_read !== 1'b1) begin fails++; $display("FAIL rstmid_read_pending: got %b required 1", flash_mem_read); end
    tests_run++; if (flash_mem_address !== 23'h1) begin fails++; $display("FAIL rstmid_addr_before: got %h required 000001", flash_mem_address); end
    rst_n = 1'b0;
    #1;
    tests_run++; if (flash_mem_read !== 1'b0) begin fails++; $display("FAIL rstmid_read_drop: got %b required 0", flash_mem_read); end
    tests_run++; if (flash_mem_address !== 23'h0) begin fails++; $display("FAIL rstmid_addr_reset: got %h required 000000", flash_mem_address); end
    tests_run++; if (audio_data !== 8'h00) begin fails++; $display("FAIL rstmid_audio: got %h required 00", audio_data); end
    repeat (2) @(negedge clk);
    enable = 1'b0;
    rst_n = 1'b1;
    addr_log.delete();
    rdv_count = 0;
    ws_cfg = 0;
    enable = 1'b1;
    wait_reads(1, "rstmid_after");
    tests_run++; if (addr_log.size() < 1 || addr_log[0] !== 23'h0) begin fails++; $display("FAIL rstmid_first_read: reads=%0d required first read at 000000", addr_log.size()); end
    enable = 1'b0;
    wait_rdv(1, "rstmid_after");
    repeat (3) @(negedge clk);
    tests_run++; if (exp_q.size() != 0) begin fails++; $display("FAIL rstmid_drain: %0d samples left, required 0", exp_q.size()); end
  endtask

  task automatic test_tick_held();
    int s0;
    do_reset();
    ws_cfg = 0; lat_cfg = 0;
    enable = 1'b1;
    wait_rdv(1, "held");
    @(negedge clk);
    @(negedge clk);
    push_word(23'h0);
    s0 = start_cnt;
    enable = 1'b0;
    sample_tick = 1'b1;
    repeat (12) @(negedge clk);
    sample_tick = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++; if (start_cnt - s0 != 4) begin fails++; $display("FAIL held_starts: got %0d required 4", start_cnt - s0); end
    tests_run++; if (flash_mem_read !== 1'b0 || addr_log.size() != 1) begin fails++; $display("FAIL held_no_refetch: reads=%0d required 1", addr_log.size()); end
    tests_run++; if (flash_mem_address !== 23'h1) begin fails++; $display("FAIL held_addr: got %h required 000001", flash_mem_address); end
    tests_run++; if (exp_q.size() != 0) begin fails++; $display("FAIL held_drain: %0d samples left, required 0", exp_q.size()); end
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    sample_tick = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_pending_underrun();
    test_disable_in_wait();
    test_reset_mid();
    test_tick_held();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
